game_dumper: RTL and testbench
==============================

# game_dumper

Reads a loaded game back out of SDRAM and streams it to the host as a well-formed iNES 2.0 file. It is the upload-direction counterpart of the loader. It first synthesises the 16-byte header from the loader's `mapper_flags` word and the exact page counts, then streams the PRG region and the CHR region. It sits between the SDRAM arbiter read port and the host upload channel.

## Interface
Parameters:
- `PRG_BASE`, 22'h000000, SDRAM byte address of PRG ROM
- `CHR_BASE`, 22'h200000, SDRAM byte address of CHR ROM

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; begins a dump; ignored unless idle/done/error
- `abort`  in  1  one-cycle pulse; returns to idle from any state
- `mapper_flags`  in  32  loader flag word: [7:0] mapper, [14] mirroring (already XORed), [16] four-screen, [24:17] submapper byte, [25] has_saves, [29:26] prgram, [30] piano
- `invert_mirroring`  in  1  same value the loader used; undoes the XOR on bit 14
- `prg_pages`  in  8  16 KiB PRG page count
- `chr_pages`  in  8  8 KiB CHR page count; 0 means CHR RAM, so there is no CHR section
- `mem_addr`  out  22  SDRAM read byte address
- `mem_rd`  out  1  read request, held until `mem_ack`
- `mem_ack`  in  1  one-cycle; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  8  read data
- `out_data`  out  8  stream byte
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready from the host
- `busy`  out  1  dump in progress
- `done`  out  1  level; the last byte was accepted
- `error`  out  1  level; the dump was rejected

## Operation
- States: S_IDLE, S_HEADER, S_RDREQ, S_SEND, S_DONE, S_ERROR. A flag `region` (PRG/CHR) selects the data source.
- On `start`, inputs are sampled into internal registers and are not re-read during the dump.
- Validation at `start`:
  - `prg_pages`==0 or `prg_pages`>128 → S_ERROR. `error`=1, `done`=1, `busy`=0, and no bytes are emitted.
  - Otherwise → S_HEADER, `busy`=1, `done`=0, `error`=0.
- Header bytes 0..15 (m = mapper_flags):
  - 0..3: 4E 45 53 1A
  - 4: `prg_pages`
  - 5: `chr_pages`
  - 6: {m[3:0], m[16], 1'b0, m[25], m[14]^invert_mirroring}
  - 7: {m[7:4], 4'b1000}
  - 8: m[24:17]
  - 9: 00
  - 10: {4'h0, m[29:26]}
  - 11..14: 00
  - 15: piano ? 8'h19 : 8'h00
- S_HEADER:
  - A 4-bit counter indexes the header bytes.
  - Each `out_valid && out_ready` advances the counter.
  - After byte 15 → S_RDREQ with `region`=PRG, `mem_addr`=`PRG_BASE`, `bytes_left`={`prg_pages`,14'b0}.
- S_RDREQ:
  - `mem_rd`=1.
  - On `mem_ack`: latch `mem_rdata` into `out_data`, drop `mem_rd`, → S_SEND.
- S_SEND:
  - `out_valid`=1.
  - On `out_ready`: `mem_addr`+1, `bytes_left`−1.
  - If `bytes_left`==1 when the byte is accepted, the region ends:
    - PRG region with `chr_pages`≠0 → `region`=CHR, `mem_addr`=`CHR_BASE`, `bytes_left`={`chr_pages`,13'b0}, → S_RDREQ.
    - PRG region with `chr_pages`==0, or CHR region → S_DONE.
  - Otherwise → S_RDREQ.
- S_DONE / S_ERROR: hold outputs until the next `start`.
- `bytes_left` is 22 bits wide. The maximum PRG size is 128 pages = 22'h200000. Address arithmetic wraps modulo 2^22 but never reaches a wrap for legal page counts.

## Timing
- Reset values: `mem_addr`=0, `mem_rd`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `error`=0, state S_IDLE.
- `start` → first header byte has `out_valid`=1 on the next cycle.
- Header throughput is 1 byte/cycle with `out_ready` held high.
- Data path per byte: 1 cycle S_RDREQ entry, then the SDRAM latency until `mem_ack`, then 1 cycle minimum in S_SEND.
- Stream rules: `out_data` is stable while `out_valid`=1 and `out_ready`=0. `out_valid` never drops without a handshake, except on `abort`/`reset`.
- `mem_rd` stays high until `mem_ack`. `mem_addr` is stable while `mem_rd`=1.
- `mem_ack` arriving outside S_RDREQ is ignored.
- `abort` or `reset` mid-operation takes effect in the next cycle: S_IDLE, and all outputs take their reset values.
- `abort` takes priority over `start` in the same cycle.
- `start` while `busy` is ignored.
- `done` rises in the cycle after the last byte is accepted.

## Structure
- Shared package holds:
  - the state enum
  - `PRG_BASE`/`CHR_BASE` constants, used by the loader as well
  - the `mapper_flags` bit-field positions
  - iNES magic constants
- One natural sub-module, `ines_header_gen`: combinational 16-byte header generator indexed by the 4-bit counter. It is unit-testable against loader parsing.

## Test plan
- prg=2, chr=1, mapper 4, mirroring=1, invert=0, out_ready=1, zero-latency memory:
  - 16+32768+8192 bytes emitted.
  - Header = 4E 45 53 1A 02 01 41 08 00…
  - First CHR read address = 22'h200000.
  - `done`=1.
- chr_pages=0: header byte 5=00; the stream ends after 16+16384 bytes; no read ≥ `CHR_BASE`.
- prg_pages=0, and separately prg_pages=129: `error`=1 and `done`=1 one cycle after `start`; `out_valid` never asserted.
- Random `out_ready` backpressure and 0–7 cycle `mem_ack` latency: `out_data` is stable under stall. The byte stream equals the memory model contents and the bench loader re-parses it to the original `mapper_flags`.
- `abort` during PRG byte 100 and `reset` during header byte 5: the next cycle is idle with all outputs zero; a following `start` produces a full, correct dump.
- piano=1, submapper 8'hF0, prgram=7, invert_mirroring=1: bytes 8/10/15 = F0/07/19; byte 6 bit 0 = raw mirroring.

Source files
------------

// File: rtl/game_dumper_pkg.sv
// Shared definitions for the SDRAM game dumper and the loader that fills SDRAM:
// FSM states, default SDRAM layout, mapper_flags field positions and iNES constants.
package game_dumper_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_RDREQ,
    S_SEND,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic {
    REGION_PRG,
    REGION_CHR
  } region_t;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned LEFT_W = 22;

  // Default SDRAM byte addresses of the PRG and CHR images
  localparam logic [ADDR_W-1:0] DEF_PRG_BASE = 22'h000000;
  localparam logic [ADDR_W-1:0] DEF_CHR_BASE = 22'h200000;

  // Largest PRG image that fits below CHR_BASE (128 x 16 KiB)
  localparam logic [7:0] MAX_PRG_PAGES = 8'd128;

  // mapper_flags bit-field positions
  localparam int unsigned MF_MAPPER_LO   = 0;
  localparam int unsigned MF_MAPPER_MID  = 4;
  localparam int unsigned MF_MAPPER_HI   = 7;
  localparam int unsigned MF_MIRROR      = 14;
  localparam int unsigned MF_FOUR_SCREEN = 16;
  localparam int unsigned MF_SUBMAP_LO   = 17;
  localparam int unsigned MF_SUBMAP_HI   = 24;
  localparam int unsigned MF_SAVES       = 25;
  localparam int unsigned MF_PRGRAM_LO   = 26;
  localparam int unsigned MF_PRGRAM_HI   = 29;
  localparam int unsigned MF_PIANO       = 30;

  // iNES / NES 2.0 constants
  localparam logic [7:0] INES_MAGIC0     = 8'h4E;
  localparam logic [7:0] INES_MAGIC1     = 8'h45;
  localparam logic [7:0] INES_MAGIC2     = 8'h53;
  localparam logic [7:0] INES_MAGIC3     = 8'h1A;
  localparam logic [3:0] INES_NES2_ID    = 4'b1000;
  localparam logic [7:0] INES_PIANO_EXP  = 8'h19;
  localparam logic [3:0] INES_HDR_LAST   = 4'd15;

endpackage

// File: rtl/ines_header_gen.sv
// Combinational NES 2.0 header generator.
// Ports: idx (header byte index 0..15), mapper_flags (loader flag word),
//        invert_mirroring (undoes the loader XOR on the mirroring bit),
//        prg_pages / chr_pages (page counts), hdr_byte_c (selected header byte).
module ines_header_gen
  import game_dumper_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic [31:0] mapper_flags,
  input  logic        invert_mirroring,
  input  logic [7:0]  prg_pages,
  input  logic [7:0]  chr_pages,
  output logic [7:0]  hdr_byte_c
);

  // Flag bits with no place in the header
  logic unused_flag_bits;
  assign unused_flag_bits = ^{mapper_flags[31], mapper_flags[15], mapper_flags[13:8]};

  // Header byte mux
  always_comb begin
    hdr_byte_c = 8'h00;
    case (idx)
      4'd0:  hdr_byte_c = INES_MAGIC0;
      4'd1:  hdr_byte_c = INES_MAGIC1;
      4'd2:  hdr_byte_c = INES_MAGIC2;
      4'd3:  hdr_byte_c = INES_MAGIC3;
      4'd4:  hdr_byte_c = prg_pages;
      4'd5:  hdr_byte_c = chr_pages;
      // The loader stored mirroring XORed with invert_mirroring; XOR again to get the raw bit
      4'd6:  hdr_byte_c = {mapper_flags[MF_MAPPER_MID-1:MF_MAPPER_LO],
                           mapper_flags[MF_FOUR_SCREEN],
                           1'b0,
                           mapper_flags[MF_SAVES],
                           mapper_flags[MF_MIRROR] ^ invert_mirroring};
      4'd7:  hdr_byte_c = {mapper_flags[MF_MAPPER_HI:MF_MAPPER_MID], INES_NES2_ID};
      4'd8:  hdr_byte_c = mapper_flags[MF_SUBMAP_HI:MF_SUBMAP_LO];
      4'd10: hdr_byte_c = {4'h0, mapper_flags[MF_PRGRAM_HI:MF_PRGRAM_LO]};
      4'd15: hdr_byte_c = mapper_flags[MF_PIANO] ? INES_PIANO_EXP : 8'h00;
      default: hdr_byte_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/game_dumper.sv
// Streams a loaded game out of SDRAM as an iNES 2.0 file: 16 synthesised header
// bytes, then the PRG image, then the CHR image (skipped when chr_pages is 0).
// Ports: clk/reset (sync, active-high); start/abort control pulses;
//        mapper_flags, invert_mirroring, prg_pages, chr_pages (sampled on start);
//        mem_addr/mem_rd/mem_ack/mem_rdata (SDRAM read port, one byte per request);
//        out_data/out_valid/out_ready (host upload stream); busy/done/error status.
module game_dumper
  import game_dumper_pkg::*;
#(
  parameter logic [21:0] PRG_BASE = DEF_PRG_BASE,
  parameter logic [21:0] CHR_BASE = DEF_CHR_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] mapper_flags,
  input  logic        invert_mirroring,
  input  logic [7:0]  prg_pages,
  input  logic [7:0]  chr_pages,
  output logic [21:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t              state;
  region_t             region;
  logic [3:0]          hdr_idx;
  logic [LEFT_W-1:0]   bytes_left;

  // Dump parameters captured at start
  logic [31:0]         flags_q;
  logic                invert_q;
  logic [7:0]          prg_q;
  logic [7:0]          chr_q;

  logic [3:0]          hdr_next_idx;
  logic [7:0]          hdr_byte_c;
  logic                prg_ok_c;
  logic                accept_c;

  assign hdr_next_idx = hdr_idx + 4'd1;
  assign prg_ok_c     = (prg_pages != 8'd0) && (prg_pages <= MAX_PRG_PAGES);
  assign accept_c     = out_valid && out_ready;

  // Header byte for the slot after the one currently presented
  ines_header_gen u_hdr (
    .idx              (hdr_next_idx),
    .mapper_flags     (flags_q),
    .invert_mirroring (invert_q),
    .prg_pages        (prg_q),
    .chr_pages        (chr_q),
    .hdr_byte_c       (hdr_byte_c)
  );

  // Dump sequencer; every output is a register
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state      <= S_IDLE;
      region     <= REGION_PRG;
      hdr_idx    <= 4'd0;
      bytes_left <= '0;
      flags_q    <= 32'd0;
      invert_q   <= 1'b0;
      prg_q      <= 8'd0;
      chr_q      <= 8'd0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            flags_q  <= mapper_flags;
            invert_q <= invert_mirroring;
            prg_q    <= prg_pages;
            chr_q    <= chr_pages;
            region   <= REGION_PRG;
            if (prg_ok_c) begin
              // Byte 0 is a constant, so it can be presented before the captured inputs settle
              state     <= S_HEADER;
              hdr_idx   <= 4'd0;
              out_data  <= INES_MAGIC0;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              done      <= 1'b0;
              error     <= 1'b0;
            end else begin
              state     <= S_ERROR;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              error     <= 1'b1;
            end
          end
        end

        S_HEADER: begin
          if (accept_c) begin
            if (hdr_idx == INES_HDR_LAST) begin
              state      <= S_RDREQ;
              region     <= REGION_PRG;
              out_valid  <= 1'b0;
              mem_addr   <= PRG_BASE;
              bytes_left <= {prg_q, 14'b0};
              mem_rd     <= 1'b1;
            end else begin
              hdr_idx  <= hdr_next_idx;
              out_data <= hdr_byte_c;
            end
          end
        end

        S_RDREQ: begin
          if (mem_ack) begin
            state     <= S_SEND;
            mem_rd    <= 1'b0;
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
          end
        end

        S_SEND: begin
          if (accept_c) begin
            out_valid  <= 1'b0;
            mem_addr   <= mem_addr + 22'd1;
            bytes_left <= bytes_left - LEFT_W'(1);
            if (bytes_left == LEFT_W'(1)) begin
              if ((region == REGION_PRG) && (chr_q != 8'd0)) begin
                state      <= S_RDREQ;
                region     <= REGION_CHR;
                mem_addr   <= CHR_BASE;
                bytes_left <= LEFT_W'({chr_q, 13'b0});
                mem_rd     <= 1'b1;
              end else begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              state  <= S_RDREQ;
              mem_rd <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_dumper.sv
// Self-checking bench for game_dumper: randomised memory latency and host
// backpressure, expected stream built from the iNES rules and a memory model.
module tb_game_dumper;

  localparam logic [21:0] PRG_BASE = 22'h000000;
  localparam logic [21:0] CHR_BASE = 22'h200000;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] mapper_flags;
  logic        invert_mirroring;
  logic [7:0]  prg_pages, chr_pages;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy, done, error;

  always #5 clk = ~clk;

  game_dumper #(.PRG_BASE(PRG_BASE), .CHR_BASE(CHR_BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mapper_flags(mapper_flags), .invert_mirroring(invert_mirroring),
    .prg_pages(prg_pages), .chr_pages(chr_pages),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  cap[$];
  logic [21:0] rd_addr[$];
  int ready_pct = 100;
  int lat_max = 0;
  int stall_viol = 0;
  int addr_viol = 0;

  logic [7:0]  exp_hdr [16];
  logic [31:0] cur_m;
  logic        cur_inv;
  int          cur_prg, cur_chr;

  function automatic logic [7:0] mem_model(input logic [21:0] a);
    return 8'((a * 22'd37) ^ (a >> 9));
  endfunction

  // Host sink: random ready, capture accepted bytes, watch stability under stall
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (prev_stall && !(out_valid === 1'b1 && out_data === prev_data)) stall_viol++;
    out_ready = ($urandom_range(0, 99) < ready_pct);
    if (out_valid === 1'b1 && out_ready) cap.push_back(out_data);
    prev_stall = (out_valid === 1'b1) && !out_ready;
    prev_data  = out_data;
  end

  // SDRAM model: random latency, one-cycle ack, address stability watch
  int          wait_cnt = 0;
  int          cur_lat = 0;
  logic [21:0] req_addr = '0;
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_rd === 1'b1) begin
      if (wait_cnt == 0) req_addr = mem_addr;
      else if (mem_addr !== req_addr) addr_viol++;
      if (wait_cnt >= cur_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_model(mem_addr);
        rd_addr.push_back(mem_addr);
        cur_lat   = $urandom_range(0, lat_max);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic make_header(input logic [31:0] m, input logic inv, input int prg, input int chr);
    int mapper, mir, fs, sv, sub, pr, pi;
    mapper = int'(m & 32'hFF);
    mir    = int'((m >> 14) & 32'd1) ^ int'(inv);
    fs     = int'((m >> 16) & 32'd1);
    sub    = int'((m >> 17) & 32'hFF);
    sv     = int'((m >> 25) & 32'd1);
    pr     = int'((m >> 26) & 32'hF);
    pi     = int'((m >> 30) & 32'd1);
    for (int i = 0; i < 16; i++) exp_hdr[i] = 8'h00;
    exp_hdr[0]  = 8'h4E; exp_hdr[1] = 8'h45; exp_hdr[2] = 8'h53; exp_hdr[3] = 8'h1A;
    exp_hdr[4]  = 8'(prg);
    exp_hdr[5]  = 8'(chr);
    exp_hdr[6]  = 8'((mapper % 16) * 16 + fs * 8 + sv * 2 + mir);
    exp_hdr[7]  = 8'((mapper / 16) * 16 + 8);
    exp_hdr[8]  = 8'(sub);
    exp_hdr[10] = 8'(pr);
    exp_hdr[15] = (pi != 0) ? 8'h19 : 8'h00;
    cur_m = m; cur_inv = inv; cur_prg = prg; cur_chr = chr;
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    int j, prg_len;
    if (i < 16) return exp_hdr[i];
    j = i - 16;
    prg_len = cur_prg * 16384;
    if (j < prg_len) return mem_model(PRG_BASE + 22'(j));
    return mem_model(CHR_BASE + 22'(j - prg_len));
  endfunction

  // Host-side loader: rebuild the flag word from the captured header
  function automatic logic [31:0] reparse(input logic inv);
    int h6, h7;
    logic [31:0] f;
    h6 = int'(cap[6]); h7 = int'(cap[7]);
    f  = 32'(h6 / 16 + (h7 / 16) * 16);
    f |= 32'(((h6 % 2) ^ int'(inv))) << 14;
    f |= 32'((h6 / 8) % 2) << 16;
    f |= 32'(cap[8]) << 17;
    f |= 32'((h6 / 2) % 2) << 25;
    f |= 32'(int'(cap[10]) % 16) << 26;
    f |= 32'(cap[15] == 8'h19) << 30;
    return f;
  endfunction

  task automatic do_start(input logic [31:0] m, input logic inv, input int prg, input int chr);
    @(negedge clk);
    mapper_flags = m; invert_mirroring = inv;
    prg_pages = 8'(prg); chr_pages = 8'(chr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cap(input int n, input int budget, input string name);
    int c = 0;
    while (cap.size() < n && c < budget) begin @(negedge clk); c++; end
    n_cmp++;
    if (cap.size() < n) begin
      n_bad++; $display("FAIL %s_timeout: captured %0d bytes, required %0d", name, cap.size(), n);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin @(negedge clk); c++; end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, c);
    end
  endtask

  task automatic check_stream(input string name);
    n_cmp++;
    for (int i = 0; i < cap.size(); i++) begin
      if (cap[i] !== exp_byte(i)) begin
        n_bad++;
        $display("FAIL %s_stream: byte %0d got %02h required %02h", name, i, cap[i], exp_byte(i));
        break;
      end
    end
  endtask

  task automatic check_reparse(input string name);
    logic [31:0] got;
    got = reparse(cur_inv);
    n_cmp++;
    if (got !== (cur_m & 32'h7FFF40FF)) begin
      n_bad++; $display("FAIL %s_reparse: got %08h required %08h", name, got, cur_m & 32'h7FFF40FF);
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_cmp++;
    if ({mem_addr, mem_rd, out_data, out_valid, busy, done, error} !== 36'd0) begin
      n_bad++;
      $display("FAIL %s_outputs_zero: addr=%h rd=%b data=%h valid=%b busy=%b done=%b error=%b required all 0",
               name, mem_addr, mem_rd, out_data, out_valid, busy, done, error);
    end
  endtask

  task automatic kill_dump(input bit use_reset);
    @(negedge clk);
    if (use_reset) reset = 1'b1; else abort = 1'b1;
    @(negedge clk);
    reset = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");
  endtask

  task automatic test_error();
    int bad_pages [2] = '{0, 129};
    for (int k = 0; k < 2; k++) begin
      cap.delete();
      do_start(32'h0000_0004, 1'b0, bad_pages[k], 1);
      n_cmp++;
      if ({error, done, busy, out_valid} !== 4'b1100) begin
        n_bad++; $display("FAIL error_prg%0d_status: {error,done,busy,valid}=%b required 1100",
                          bad_pages[k], {error, done, busy, out_valid});
      end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (cap.size() != 0 || mem_rd !== 1'b0) begin
        n_bad++; $display("FAIL error_prg%0d_quiet: bytes=%0d mem_rd=%b required 0/0", bad_pages[k], cap.size(), mem_rd);
      end
    end
  endtask

  task automatic test_abort();
    ready_pct = 100; lat_max = 0; cap.delete();
    make_header($urandom(), 1'b0, 2, 1);
    do_start(cur_m, cur_inv, cur_prg, cur_chr);
    wait_cap(16 + 100, 2000, "abort");
    kill_dump(1'b0);
    check_idle_zero("abort");
    check_stream("abort_prefix");
  endtask

  task automatic test_reset_mid();
    ready_pct = 100; lat_max = 0; cap.delete();
    make_header($urandom(), 1'b1, 5, 3);
    do_start(cur_m, cur_inv, cur_prg, cur_chr);
    wait_cap(5, 100, "reset_mid");
    kill_dump(1'b1);
    check_idle_zero("reset_mid");
  endtask

  task automatic test_chr_ram();
    bit hi_read;
    ready_pct = 100; lat_max = 0; cap.delete(); rd_addr.delete();
    make_header($urandom(), 1'b0, 1, 0);
    do_start(cur_m, cur_inv, cur_prg, cur_chr);
    wait_done(40000, "chr_ram");
    n_cmp++;
    if (cap.size() != 16 + 16384) begin
      n_bad++; $display("FAIL chr_ram_length: got %0d bytes required %0d", cap.size(), 16 + 16384);
    end
    n_cmp++;
    if (cap[5] !== 8'h00) begin
      n_bad++; $display("FAIL chr_ram_byte5: got %02h required 00", cap[5]);
    end
    hi_read = 1'b0;
    foreach (rd_addr[i]) if (rd_addr[i] >= CHR_BASE) hi_read = 1'b1;
    n_cmp++;
    if (hi_read || rd_addr.size() != 16384) begin
      n_bad++; $display("FAIL chr_ram_reads: chr_read=%0b reads=%0d required 0/16384", hi_read, rd_addr.size());
    end
    check_stream("chr_ram");
    check_reparse("chr_ram");
  endtask

  task automatic test_basic();
    logic [7:0] hdr_const [8] = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h01, 8'h41, 8'h08};
    int first_chr;
    ready_pct = 100; lat_max = 0; cap.delete(); rd_addr.delete();
    make_header(32'h0000_4004, 1'b0, 1, 1);
    do_start(cur_m, cur_inv, cur_prg, cur_chr);
    n_cmp++;
    if ({out_valid, busy, out_data} !== {2'b11, 8'h4E}) begin
      n_bad++; $display("FAIL basic_first_byte: valid=%b busy=%b data=%02h required 1/1/4E", out_valid, busy, out_data);
    end
    // A start mid-dump with illegal counts must be ignored, and the new inputs never re-read
    wait_cap(50, 500, "basic");
    do_start(32'hFFFF_FFFF, 1'b1, 0, 0);
    wait_done(60000, "basic");
    n_cmp++;
    if ({done, error, busy, out_valid} !== 4'b1000) begin
      n_bad++; $display("FAIL basic_final_status: {done,error,busy,valid}=%b required 1000", {done, error, busy, out_valid});
    end
    n_cmp++;
    if (cap.size() != 16 + 16384 + 8192) begin
      n_bad++; $display("FAIL basic_length: got %0d bytes required %0d", cap.size(), 16 + 16384 + 8192);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap[i] !== hdr_const[i]) begin
        n_bad++; $display("FAIL basic_hdr%0d: got %02h required %02h", i, cap[i], hdr_const[i]);
      end
    end
    first_chr = -1;
    foreach (rd_addr[i]) if (first_chr < 0 && rd_addr[i] >= CHR_BASE) first_chr = i;
    n_cmp++;
    if (first_chr != 16384 || rd_addr[16384] !== CHR_BASE) begin
      n_bad++; $display("FAIL basic_chr_addr: first CHR read index %0d addr %h required 16384 / %h",
                        first_chr, rd_addr[16384], CHR_BASE);
    end
    check_stream("basic");
    check_reparse("basic");
  endtask

  task automatic test_piano();
    logic [31:0] m;
    ready_pct = 100; lat_max = 0; cap.delete();
    m = (32'd1 << 30) | (32'd7 << 26) | (32'hF0 << 17) | (32'd1 << 14) | 32'h0000_00A5;
    make_header(m, 1'b1, 3, 2);
    do_start(cur_m, cur_inv, cur_prg, cur_chr);
    wait_cap(40, 500, "piano");
    kill_dump(1'b0);
    n_cmp++;
    if ({cap[8], cap[10], cap[15]} !== 24'hF0_07_19) begin
      n_bad++; $display("FAIL piano_bytes: 8/10/15 got %02h/%02h/%02h required F0/07/19", cap[8], cap[10], cap[15]);
    end
    n_cmp++;
    if (cap[6][0] !== 1'b0) begin
      n_bad++; $display("FAIL piano_raw_mirror: got %b required 0", cap[6][0]);
    end
    check_stream("piano");
    check_reparse("piano");
  endtask

  task automatic test_backpressure();
    for (int it = 0; it < 2; it++) begin
      ready_pct = 50; lat_max = 7; cap.delete();
      stall_viol = 0; addr_viol = 0;
      make_header($urandom(), 1'($urandom_range(0, 1)), $urandom_range(1, 128), $urandom_range(0, 255));
      do_start(cur_m, cur_inv, cur_prg, cur_chr);
      wait_cap(250, 8000, "backpressure");
      ready_pct = 100;
      repeat (2) @(negedge clk);
      kill_dump(1'b0);
      @(negedge clk);
      n_cmp++;
      if (stall_viol != 0 || addr_viol != 0) begin
        n_bad++; $display("FAIL backpressure_stability: data changes %0d addr changes %0d required 0/0", stall_viol, addr_viol);
      end
      check_stream("backpressure");
      check_reparse("backpressure");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    mapper_flags = 32'd0; invert_mirroring = 1'b0;
    prg_pages = 8'd0; chr_pages = 8'd0;
    mem_ack = 1'b0; mem_rdata = 8'd0; out_ready = 1'b1;
    test_reset();
    test_error();
    test_abort();
    test_reset_mid();
    test_chr_ram();
    test_basic();
    test_piano();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
